// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of the two requester handshakes (instruction
// fetch and load/store) plus the shared memory port.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants,
//            read returns and the memory strobe/address/data)
//   master : environment view (requesters and memory), directions reversed
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    // instruction-fetch requester
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;
    // load/store requester
    logic                  ls_req;
    logic                  ls_we;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [DATA_WIDTH-1:0] ls_wdata;
    logic                  ls_gnt;
    logic                  ls_rvalid;
    logic [DATA_WIDTH-1:0] ls_rdata;
    // memory port
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the instruction-fetch (IF)
// and load/store (LS) requesters. One access is granted at a time; a read
// keeps the port busy for MEM_LATENCY cycles and returns the data to its
// owner. Simultaneous requests are resolved round-robin against the last
// winner.
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : slave view of mem_port_arbiter_if (requests, grants, read
//            returns, memory strobe/address/data)
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int MEM_LATENCY = 1    // 1..7
) (
    input  logic                  clk,
    input  logic                  resetn,
    mem_port_arbiter_if.slave     bus
);
    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    typedef enum logic { IDLE, READ_WAIT } state_t;
    typedef enum logic { OWN_IF, OWN_LS }  owner_t;

    state_t     state, state_nxt;
    owner_t     owner, owner_nxt;
    owner_t     last_owner, last_owner_nxt;
    logic [2:0] wait_cnt, wait_cnt_nxt;

    logic                  pick_if, pick_ls;
    logic                  if_gnt, ls_gnt, if_rvalid, ls_rvalid;
    logic                  mem_en, mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata, if_rdata, ls_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            last_owner <= OWN_IF;
            wait_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            wait_cnt   <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        wait_cnt_nxt   = wait_cnt;
        pick_if        = 1'b0;
        pick_ls        = 1'b0;
        if_gnt         = 1'b0;
        ls_gnt         = 1'b0;
        if_rvalid      = 1'b0;
        ls_rvalid      = 1'b0;
        if_rdata       = '0;
        ls_rdata       = '0;
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;

        case (state)
            IDLE: begin
                // Grants are combinational from req, so they are gated by
                // resetn to stay low while reset is held.
                if (resetn) begin
                    pick_ls = bus.ls_req && (!bus.if_req || last_owner == OWN_IF);
                    pick_if = bus.if_req && !pick_ls;
                end
                if (pick_ls) begin
                    ls_gnt         = 1'b1;
                    mem_en         = 1'b1;
                    mem_addr       = bus.ls_addr;
                    last_owner_nxt = OWN_LS;
                    if (bus.ls_we) begin
                        // Stores complete in the grant cycle; stay IDLE.
                        mem_we    = 1'b1;
                        mem_wdata = bus.ls_wdata;
                    end else begin
                        state_nxt    = READ_WAIT;
                        owner_nxt    = OWN_LS;
                        wait_cnt_nxt = LAT;
                    end
                end else if (pick_if) begin
                    if_gnt         = 1'b1;
                    mem_en         = 1'b1;
                    mem_addr       = bus.if_addr;
                    last_owner_nxt = OWN_IF;
                    state_nxt      = READ_WAIT;
                    owner_nxt      = OWN_IF;
                    wait_cnt_nxt   = LAT;
                end
            end
            READ_WAIT: begin
                wait_cnt_nxt = wait_cnt - 3'd1;
                // Counter value 1 marks the cycle the memory data is valid.
                if (wait_cnt == 3'd1) begin
                    state_nxt = IDLE;
                    if (owner == OWN_LS) begin
                        ls_rvalid = 1'b1;
                        ls_rdata  = bus.mem_rdata;
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = bus.mem_rdata;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.if_rvalid = if_rvalid;
    assign bus.if_rdata  = if_rdata;
    assign bus.ls_gnt    = ls_gnt;
    assign bus.ls_rvalid = ls_rvalid;
    assign bus.ls_rdata  = ls_rdata;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LATENCY 1 and 3) driven
// through their interfaces, compared every cycle against a cycle-numbered
// model (port free-at cycle, read due cycle, last winner), plus directed
// sequences with literal expectations.
module tb_mem_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        d_if_req[2];
    logic [15:0] d_if_addr[2];
    logic        d_ls_req[2];
    logic        d_ls_we[2];
    logic [15:0] d_ls_addr[2];
    logic [15:0] d_ls_wdata[2];
    logic [15:0] d_mem_rdata[2];

    logic        o_if_gnt[2], o_if_rvalid[2], o_ls_gnt[2], o_ls_rvalid[2];
    logic        o_mem_en[2], o_mem_we[2];
    logic [15:0] o_if_rdata[2], o_ls_rdata[2], o_mem_addr[2], o_mem_wdata[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
        mem_port_arbiter #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .MEM_LATENCY((g == 0) ? 1 : 3)
        ) dut (
            .clk   (clk),
            .resetn(resetn),
            .bus   (bus.slave)
        );
        assign bus.if_req    = d_if_req[g];
        assign bus.if_addr   = d_if_addr[g];
        assign bus.ls_req    = d_ls_req[g];
        assign bus.ls_we     = d_ls_we[g];
        assign bus.ls_addr   = d_ls_addr[g];
        assign bus.ls_wdata  = d_ls_wdata[g];
        assign bus.mem_rdata = d_mem_rdata[g];
        assign o_if_gnt[g]    = bus.if_gnt;
        assign o_if_rvalid[g] = bus.if_rvalid;
        assign o_if_rdata[g]  = bus.if_rdata;
        assign o_ls_gnt[g]    = bus.ls_gnt;
        assign o_ls_rvalid[g] = bus.ls_rvalid;
        assign o_ls_rdata[g]  = bus.ls_rdata;
        assign o_mem_en[g]    = bus.mem_en;
        assign o_mem_we[g]    = bus.mem_we;
        assign o_mem_addr[g]  = bus.mem_addr;
        assign o_mem_wdata[g] = bus.mem_wdata;
    end

    // ---------------- model ----------------
    int          cyc;
    int          free_at[2];   // first cycle a new grant is allowed
    int          due[2];       // cycle of the pending read return, -1 none
    bit          own_ls[2];
    bit          last_ls[2];
    logic [15:0] rd_addr[2];
    bit          e_if_gnt[2], e_ls_gnt[2];
    logic [15:0] mem [logic [16:0]];

    int checks   = 0;
    int failures = 0;

    function automatic int lat(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic logic [15:0] word_at(input int g, input logic [15:0] a);
        logic [16:0] key;
        key = {g[0], a};
        if (mem.exists(key)) return mem[key];
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    task automatic cmp(input string nm, input int g, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d actual=%h expected=%h", nm, g, cyc, act, exp);
        end
    endtask

    task automatic model_update();
        for (int g = 0; g < 2; g++) begin
            if (!resetn) begin
                free_at[g] = 0;
                due[g]     = -1;
                last_ls[g] = 1'b0;
            end else if (e_ls_gnt[g] && d_ls_we[g]) begin
                mem[{g[0], d_ls_addr[g]}] = d_ls_wdata[g];
                free_at[g] = cyc + 1;
                last_ls[g] = 1'b1;
            end else if (e_ls_gnt[g] || e_if_gnt[g]) begin
                last_ls[g] = e_ls_gnt[g];
                own_ls[g]  = e_ls_gnt[g];
                rd_addr[g] = e_ls_gnt[g] ? d_ls_addr[g] : d_if_addr[g];
                due[g]     = cyc + lat(g);
                free_at[g] = cyc + lat(g) + 1;
            end
        end
    endtask

    // Advance to the next cycle: model consumes the finished cycle, then the
    // memory presents valid data only in the cycle a read is due.
    task automatic adv();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        for (int g = 0; g < 2; g++)
            d_mem_rdata[g] = (resetn && due[g] == cyc) ? word_at(g, rd_addr[g])
                                                       : 16'($urandom);
    endtask

    // Compare every output of both instances against the model.
    task automatic chk();
        bit          ig, lg, iv, lv, en, we, pl;
        logic [15:0] ird, lrd, ad, wd;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            ig = 0; lg = 0; iv = 0; lv = 0; en = 0; we = 0;
            ird = '0; lrd = '0; ad = '0; wd = '0;
            if (resetn) begin
                if (due[g] == cyc) begin
                    if (own_ls[g]) begin lv = 1; lrd = d_mem_rdata[g]; end
                    else           begin iv = 1; ird = d_mem_rdata[g]; end
                end
                if (cyc >= free_at[g]) begin
                    pl = d_ls_req[g] && (!d_if_req[g] || !last_ls[g]);
                    lg = pl;
                    ig = d_if_req[g] && !pl;
                    if (lg) begin
                        en = 1; ad = d_ls_addr[g];
                        if (d_ls_we[g]) begin we = 1; wd = d_ls_wdata[g]; end
                    end else if (ig) begin
                        en = 1; ad = d_if_addr[g];
                    end
                end
            end
            e_if_gnt[g] = ig;
            e_ls_gnt[g] = lg;
            cmp("if_gnt",    g, 16'(o_if_gnt[g]),    16'(ig));
            cmp("ls_gnt",    g, 16'(o_ls_gnt[g]),    16'(lg));
            cmp("if_rvalid", g, 16'(o_if_rvalid[g]), 16'(iv));
            cmp("ls_rvalid", g, 16'(o_ls_rvalid[g]), 16'(lv));
            cmp("if_rdata",  g, o_if_rdata[g],       ird);
            cmp("ls_rdata",  g, o_ls_rdata[g],       lrd);
            cmp("mem_en",    g, 16'(o_mem_en[g]),    16'(en));
            cmp("mem_we",    g, 16'(o_mem_we[g]),    16'(we));
            cmp("mem_addr",  g, o_mem_addr[g],       ad);
            cmp("mem_wdata", g, o_mem_wdata[g],      wd);
        end
    endtask

    task automatic set_if(input int g, input logic r, input logic [15:0] a);
        d_if_req[g] = r; d_if_addr[g] = a;
    endtask

    task automatic set_ls(input int g, input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] d);
        d_ls_req[g] = r; d_ls_we[g] = w; d_ls_addr[g] = a; d_ls_wdata[g] = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            adv();
            for (int g = 0; g < 2; g++) begin
                set_if(g, 0, '0);
                set_ls(g, 0, 0, '0, '0);
            end
            chk();
        end
    endtask

    // Random requesters: hold until granted, sometimes re-request at once,
    // occasionally give up before being granted.
    task automatic agents();
        for (int g = 0; g < 2; g++) begin
            if (d_if_req[g]) begin
                if (e_if_gnt[g]) begin
                    if ($urandom_range(0, 1) == 1) set_if(g, 1, 16'($urandom_range(0, 63)));
                    else                           set_if(g, 0, d_if_addr[g]);
                end else if ($urandom_range(0, 15) == 0) begin
                    d_if_req[g] = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                set_if(g, 1, 16'($urandom_range(0, 63)));
            end
            if (d_ls_req[g]) begin
                if (e_ls_gnt[g]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_ls(g, 1, ($urandom_range(0, 2) == 0),
                               16'($urandom_range(0, 63)), 16'($urandom));
                    else
                        d_ls_req[g] = 0;
                end else if ($urandom_range(0, 15) == 0) begin
                    d_ls_req[g] = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                set_ls(g, 1, ($urandom_range(0, 2) == 0),
                       16'($urandom_range(0, 63)), 16'($urandom));
            end
        end
    endtask

    initial begin
        cyc = 0;
        for (int g = 0; g < 2; g++) begin
            free_at[g] = 0; due[g] = -1; own_ls[g] = 0; last_ls[g] = 0;
            rd_addr[g] = '0; e_if_gnt[g] = 0; e_ls_gnt[g] = 0;
            d_mem_rdata[g] = '0;
            set_if(g, 1, 16'h0010);
            set_ls(g, 1, 0, 16'h0020, 16'h0000);
        end
        mem[{1'b0, 16'h0010}] = 16'hA5A5;

        // Reset held with both requests high: everything stays low.
        for (int i = 0; i < 3; i++) begin
            adv();
            chk();
            cmp("rst_if_gnt", 0, 16'(o_if_gnt[0]), 16'd0);
            cmp("rst_ls_gnt", 0, 16'(o_ls_gnt[0]), 16'd0);
            cmp("rst_mem_en", 0, 16'(o_mem_en[0]), 16'd0);
            cmp("rst_mem_we", 0, 16'(o_mem_we[0]), 16'd0);
        end
        // Release: LS wins the first conflict.
        adv(); resetn = 1; chk();
        cmp("first_ls_gnt", 0, 16'(o_ls_gnt[0]), 16'd1);
        cmp("first_if_gnt", 0, 16'(o_if_gnt[0]), 16'd0);
        cmp("first_ls_gnt", 1, 16'(o_ls_gnt[1]), 16'd1);
        idle(5);

        // Single fetch, latency 1.
        adv(); set_if(0, 1, 16'h0010); chk();
        cmp("fetch_gnt",  0, 16'(o_if_gnt[0]), 16'd1);
        cmp("fetch_en",   0, 16'(o_mem_en[0]), 16'd1);
        cmp("fetch_addr", 0, o_mem_addr[0],    16'h0010);
        adv(); set_if(0, 0, 16'h0010); chk();
        cmp("fetch_rvalid", 0, 16'(o_if_rvalid[0]), 16'd1);
        cmp("fetch_rdata",  0, o_if_rdata[0],       16'hA5A5);
        adv(); set_if(0, 1, 16'h0030); chk();
        cmp("fetch_next_gnt", 0, 16'(o_if_gnt[0]), 16'd1);
        idle(2);

        // Store with a fetch held: store first, fetch granted next cycle.
        adv(); set_ls(0, 1, 1, 16'h0200, 16'h1234); set_if(0, 1, 16'h0040); chk();
        cmp("store_gnt",   0, 16'(o_ls_gnt[0]), 16'd1);
        cmp("store_we",    0, 16'(o_mem_we[0]), 16'd1);
        cmp("store_wdata", 0, o_mem_wdata[0],   16'h1234);
        cmp("store_if_gnt",0, 16'(o_if_gnt[0]), 16'd0);
        adv(); set_ls(0, 0, 0, 16'h0200, 16'h0000); chk();
        cmp("after_store_if_gnt", 0, 16'(o_if_gnt[0]),    16'd1);
        cmp("store_no_rvalid",    0, 16'(o_ls_rvalid[0]), 16'd0);
        idle(2);

        // Conflict fairness with both loads held high.
        for (int k = 0; k < 8; k++) begin
            adv();
            set_ls(0, 1, 0, 16'h0100, 16'h0000);
            set_if(0, 1, 16'h0080);
            chk();
            if (k % 2 == 0) begin
                cmp("fair_ls_gnt", 0, 16'(o_ls_gnt[0]), 16'(k % 4 == 0));
                cmp("fair_if_gnt", 0, 16'(o_if_gnt[0]), 16'(k % 4 == 2));
            end else begin
                cmp("fair_ls_rvalid", 0, 16'(o_ls_rvalid[0]), 16'(k % 4 == 1));
                cmp("fair_if_rvalid", 0, 16'(o_if_rvalid[0]), 16'(k % 4 == 3));
            end
        end
        idle(2);

        // Latency 3: load in N, rvalid only in N+3, fetch held off until N+4.
        adv(); set_ls(1, 1, 0, 16'h0300, 16'h0000); chk();
        cmp("lat3_ls_gnt", 1, 16'(o_ls_gnt[1]), 16'd1);
        for (int k = 1; k <= 4; k++) begin
            adv(); set_ls(1, 0, 0, 16'h0300, 16'h0000); set_if(1, 1, 16'h0050); chk();
            cmp("lat3_ls_rvalid", 1, 16'(o_ls_rvalid[1]), 16'(k == 3));
            cmp("lat3_if_gnt",    1, 16'(o_if_gnt[1]),    16'(k == 4));
        end
        idle(4);

        // Reset during READ_WAIT discards the read.
        adv(); set_if(1, 1, 16'h0060); chk();
        cmp("rmid_gnt", 1, 16'(o_if_gnt[1]), 16'd1);
        adv(); set_if(1, 0, 16'h0060); chk();
        adv(); resetn = 0; chk();
        cmp("rmid_rvalid_in_rst", 1, 16'(o_if_rvalid[1]), 16'd0);
        adv(); resetn = 1; chk();
        cmp("rmid_rvalid_after", 1, 16'(o_if_rvalid[1]), 16'd0);
        adv(); set_if(1, 1, 16'h0070); chk();
        cmp("rmid_regrant", 1, 16'(o_if_gnt[1]), 16'd1);
        idle(4);

        // Random traffic with rare resets.
        for (int n = 0; n < 4000; n++) begin
            adv();
            resetn = ($urandom_range(0, 499) != 0);
            agents();
            chk();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
